mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64, memory bus width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 64, address width.
REQ-003 SHALL have parameter BASE_ADDR, default 64'h8000_0000, byte address of memory word index 0.
REQ-004 SHALL have parameter CNT_W, default 32, width of the split-access counter.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  1  access request.
REQ-008 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-009 req_wen  in  1  1 = store, 0 = load.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-012 req_unsigned  in  1  zero-extend load result.
REQ-013 req_wdata  in  DATA_W  store data, right-aligned.
REQ-014 resp_valid  out  1  one-cycle completion pulse for both loads and stores.
REQ-015 resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
REQ-016 resp_err  out  1  unsupported size; valid with resp_valid.
REQ-017 busy  out  1  high in every non-IDLE state; feeds the hazard stall.
REQ-018 mem_en, mem_wen  out  1 each  read enable, write enable.
REQ-019 mem_idx  out  ADDR_W  word index.
REQ-020 mem_wdata, mem_wmask  out  DATA_W each  write data, bit mask.
REQ-021 mem_rdata  in  DATA_W  read data, valid the cycle after mem_en.
REQ-022 split_cnt  out  CNT_W  count of split accesses.

Function
REQ-023 FSM states SHALL be IDLE, ACC0, ACC1, DONE; req_ready = (state == IDLE).
REQ-024 On an accepted request the block SHALL latch all req_* fields and go to ACC0, or to DONE when the request is an error.
REQ-025 Definitions: B = DATA_W/8; off = addr mod B; n = 1 << size; split = (off + n > B); mem_idx0 = (addr - BASE_ADDR) >> log2(B).
REQ-026 An access SHALL be an error when n > B, for example size 3 with DATA_W = 32; errors issue no memory access.
REQ-027 Byte enables SHALL be the 2B-bit value ((1 << n) - 1) << off; beat0 uses the low B bits, beat1 uses the high B bits; mem_wmask expands each byte enable to 8 bits.
REQ-028 Write data SHALL be the 2*DATA_W-bit value wdata << (8*off), split into low and high halves for beat0 and beat1.
REQ-029 In ACC0 the block SHALL drive beat0 with mem_idx = mem_idx0, then go to ACC1 if split, otherwise to DONE.
REQ-030 In ACC1 the block SHALL drive beat1 with mem_idx = mem_idx0 + 1, capture the beat0 mem_rdata, then go to DONE.
REQ-031 In DONE the block SHALL capture the final beat, assert resp_valid for exactly one cycle, and return to IDLE.
REQ-032 Load data SHALL be {beat1, beat0} >> (8*off), truncated to n bytes, sign- or zero-extended to DATA_W.
REQ-033 Latency from the accept edge SHALL be: aligned, resp_valid 2 cycles later; split, 3 cycles later; error, 1 cycle later.
REQ-034 mem_en SHALL be high in ACC0 and ACC1 for loads only, and mem_wen high in ACC0 and ACC1 for stores only; both SHALL be 0 in IDLE and DONE.
REQ-035 split_cnt SHALL increment on entry to ACC1 and saturate at all-ones.
REQ-036 resp has no backpressure; no request is accepted in the DONE cycle.

Reset
REQ-037 While rst is high, mem_en, mem_wen, resp_valid and resp_err SHALL be forced to 0 combinationally.
REQ-038 On the reset edge state SHALL become IDLE, split_cnt and latched fields SHALL become 0, and any in-flight access SHALL be dropped with no response.
REQ-039 After reset req_ready = 1, busy = 0, resp_rdata = 0, mem_idx = 0, mem_wdata = 0, mem_wmask = 0.

Structure
REQ-040 Size encodings, FSM state codes and BASE_ADDR default SHALL live in the shared defines.v.
REQ-041 Combinational shift, mask and extend logic SHALL be one sub-module, mem_align; the FSM, latches and counter stay in mem_access_unit.

Verification (DATA_W = 64, BASE_ADDR = 0x8000_0000)
REQ-042 Aligned load: LD 0x8000_0010, word 2 = 0x1122334455667788 -> mem_idx 2, resp_rdata 0x1122334455667788 two cycles after accept.
REQ-043 Byte load at 0x8000_0003 with byte3 = 0x80: LB -> 0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
REQ-044 Split store: SW 0x8000_0006, data 0xAABBCCDD -> beat0 idx 0, byte enables 0xC0, wdata 0xCCDD_0000_0000_0000; beat1 idx 1, byte enables 0x03, wdata 0xAABB; resp 3 cycles after accept; split_cnt = 1.
REQ-045 Split load: LD 0x8000_0004, word 0 = 0x8877665544332211, word 1 = 0xAABBCCDD -> resp_rdata 0xAABBCCDD88776655.
REQ-046 rst asserted in ACC1 of a split store -> mem_wen 0 that cycle, IDLE next cycle, no resp_valid, split_cnt = 0.
REQ-047 DATA_W = 32 instance, size 3 -> resp_valid and resp_err 1 cycle after accept, mem_en never asserted.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit: size encodings, FSM states and
// the default memory base address.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SzByte   = 2'd0,
        SzHalf   = 2'd1,
        SzWord   = 2'd2,
        SzDouble = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc0 = 2'd1,
        StAcc1 = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam logic [63:0] DefaultBaseAddr = 64'h8000_0000;

    function automatic int unsigned size_bytes(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between a requester (master) and the memory access unit (slave).
interface mem_access_unit_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_unit_align.sv
// Combinational lane logic: byte enables, write-data shifting and load extraction/extension
// across a two-beat window of the memory bus.
module mem_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    localparam int unsigned B     = DATA_W / 8,
    localparam int unsigned OFF_W = $clog2(B),
    localparam int unsigned BE_W  = 2 * B
) (
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rbeat0_i,
    input  logic [DATA_W-1:0] rbeat1_i,
    output logic              err_o,
    output logic              split_o,
    output logic [DATA_W-1:0] wdata0_o,
    output logic [DATA_W-1:0] wdata1_o,
    output logic [DATA_W-1:0] wmask0_o,
    output logic [DATA_W-1:0] wmask1_o,
    output logic [DATA_W-1:0] rdata_o
);
    int unsigned         nbytes;
    int unsigned         nbits;
    int unsigned         off_int;
    logic [BE_W-1:0]     be;
    logic [2*DATA_W-1:0] wfull;
    logic [DATA_W-1:0]   rlow;
    logic [DATA_W-1:0]   lowmask;
    logic [DATA_W-1:0]   sign_src;
    logic                sign;

    always_comb begin
        nbytes   = size_bytes(size_i);
        nbits    = 8 * nbytes;
        off_int  = 32'(off_i);
        err_o    = nbytes > B;
        split_o  = (off_int + nbytes) > B;

        be = (BE_W'(1) << nbytes) - BE_W'(1);
        be = be << off_int;
        wfull    = {{DATA_W{1'b0}}, wdata_i} << (8 * off_int);
        wdata0_o = wfull[DATA_W-1:0];
        wdata1_o = wfull[2*DATA_W-1:DATA_W];
        wmask0_o = '0;
        wmask1_o = '0;
        for (int i = 0; i < int'(B); i++) begin
            wmask0_o[8*i +: 8] = {8{be[i]}};
            wmask1_o[8*i +: 8] = {8{be[B+i]}};
        end

        rlow     = DATA_W'({rbeat1_i, rbeat0_i} >> (8 * off_int));
        lowmask  = '1;
        sign_src = '0;
        sign     = 1'b0;
        rdata_o  = rlow;
        // Narrower than the bus: truncate, then sign- or zero-extend.
        if (nbits < DATA_W) begin
            lowmask  = (DATA_W'(1) << nbits) - DATA_W'(1);
            sign_src = rlow >> (nbits - 1);
            sign     = sign_src[0] & ~unsigned_i;
            rdata_o  = (rlow & lowmask) | (sign ? ~lowmask : '0);
        end
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: accepts byte..double loads/stores and issues one or two bus beats,
// splitting accesses that straddle a bus word.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DefaultBaseAddr),
    parameter int unsigned       CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_idx,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  split_cnt
);
    localparam int unsigned B     = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(B);

    state_e            state_q, state_d;
    logic              wen_q, uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] wdata_q, beat0_q;
    logic [CNT_W-1:0]  split_cnt_q;

    logic              err, split, req_err, in_acc;
    logic [DATA_W-1:0] wd0, wd1, wm0, wm1, rdata_al;
    logic [ADDR_W-1:0] idx0;

    assign req_err = size_bytes(bus.req_size) > B;
    assign idx0    = (addr_q - BASE_ADDR) >> OFF_W;
    assign in_acc  = (state_q == StAcc0) || (state_q == StAcc1);

    // In DONE the final beat is still on mem_rdata; split loads pair it with the held beat0.
    mem_align #(.DATA_W(DATA_W)) u_align (
        .off_i     (addr_q[OFF_W-1:0]),
        .size_i    (size_q),
        .unsigned_i(uns_q),
        .wdata_i   (wdata_q),
        .rbeat0_i  (split ? beat0_q : mem_rdata),
        .rbeat1_i  (split ? mem_rdata : '0),
        .err_o     (err),
        .split_o   (split),
        .wdata0_o  (wd0),
        .wdata1_o  (wd1),
        .wmask0_o  (wm0),
        .wmask1_o  (wm1),
        .rdata_o   (rdata_al)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.req_valid) state_d = req_err ? StDone : StAcc0;
            StAcc0: state_d = split ? StAcc1 : StDone;
            StAcc1: state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wen_q       <= 1'b0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            beat0_q     <= '0;
            split_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && bus.req_valid) begin
                wen_q   <= bus.req_wen;
                uns_q   <= bus.req_unsigned;
                addr_q  <= bus.req_addr;
                size_q  <= bus.req_size;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == StAcc1) beat0_q <= mem_rdata;
            if (state_q == StAcc0 && split && split_cnt_q != '1) begin
                split_cnt_q <= split_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign split_cnt      = split_cnt_q;
    assign mem_en         = !rst && in_acc && !wen_q;
    assign mem_wen        = !rst && in_acc && wen_q;
    assign mem_idx        = (state_q == StAcc0) ? idx0 :
                            (state_q == StAcc1) ? idx0 + ADDR_W'(1) : '0;
    assign mem_wdata      = (in_acc && wen_q) ? ((state_q == StAcc1) ? wd1 : wd0) : '0;
    assign mem_wmask      = (in_acc && wen_q) ? ((state_q == StAcc1) ? wm1 : wm0) : '0;
    assign bus.resp_valid = !rst && (state_q == StDone);
    assign bus.resp_err   = !rst && (state_q == StDone) && err;
    assign bus.resp_rdata = (state_q == StDone && !wen_q && !err) ? rdata_al : '0;
endmodule
